// File: rtl/alarm_beep_sequencer.sv
// Alarm ring sequencer: beeps in groups of BEEPS, then a silent pause, repeated GROUPS times.
// One shared duration down-counter times every phase; snooze/stop override the sequence.
module alarm_beep_sequencer #(
    parameter int unsigned BEEP_TICKS   = 2,
    parameter int unsigned GAP_TICKS    = 2,
    parameter int unsigned BEEPS        = 3,
    parameter int unsigned PAUSE_TICKS  = 20,
    parameter int unsigned GROUPS       = 30,
    parameter int unsigned SNOOZE_TICKS = 6000,
    parameter int unsigned W            = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic alarm_en,
    input  logic alarm_match,
    input  logic snooze,
    input  logic stop,
    output logic buzzer,
    output logic ringing,
    output logic snoozing
);

    localparam int unsigned BW = (BEEPS  > 1) ? $clog2(BEEPS)  : 1;
    localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [W-1:0]  BEEP_LOAD   = W'(BEEP_TICKS - 1);
    localparam logic [W-1:0]  GAP_LOAD    = W'(GAP_TICKS - 1);
    localparam logic [W-1:0]  PAUSE_LOAD  = W'(PAUSE_TICKS - 1);
    localparam logic [W-1:0]  SNOOZE_LOAD = W'(SNOOZE_TICKS - 1);
    localparam logic [BW-1:0] BCNT_LAST   = BW'(BEEPS - 1);
    localparam logic [GW-1:0] GCNT_LAST   = GW'(GROUPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEEP,
        S_GAP,
        S_PAUSE,
        S_SNOOZE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_dcnt;
    logic [BW-1:0] r_bcnt;
    logic [GW-1:0] r_gcnt;
    logic          r_match_q;
    logic          r_match_prev;
    logic          r_buzzer;
    logic          r_ringing;
    logic          r_snoozing;

    logic w_rise;
    logic w_done;
    logic w_halt;
    logic w_active;

    // Match is sampled once before edge detection, giving the two-cycle trigger latency.
    assign w_rise   = r_match_q & ~r_match_prev;
    assign w_done   = (r_dcnt == '0);
    assign w_halt   = stop | ~alarm_en;
    assign w_active = (r_state == S_BEEP) || (r_state == S_GAP) || (r_state == S_PAUSE);

    assign buzzer   = r_buzzer;
    assign ringing  = r_ringing;
    assign snoozing = r_snoozing;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_dcnt       <= '0;
            r_bcnt       <= '0;
            r_gcnt       <= '0;
            r_match_q    <= 1'b0;
            r_match_prev <= 1'b0;
            r_buzzer     <= 1'b0;
            r_ringing    <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_match_q    <= alarm_match;
            r_match_prev <= r_match_q;

            if (w_halt) begin
                r_state    <= S_IDLE;
                r_dcnt     <= '0;
                r_bcnt     <= '0;
                r_gcnt     <= '0;
                r_buzzer   <= 1'b0;
                r_ringing  <= 1'b0;
                r_snoozing <= 1'b0;
            end else if (snooze && w_active) begin
                r_state    <= S_SNOOZE;
                r_dcnt     <= SNOOZE_LOAD;
                r_buzzer   <= 1'b0;
                r_ringing  <= 1'b1;
                r_snoozing <= 1'b1;
            end else if (r_state == S_IDLE) begin
                if (w_rise) begin
                    r_state    <= S_BEEP;
                    r_dcnt     <= BEEP_LOAD;
                    r_bcnt     <= '0;
                    r_gcnt     <= '0;
                    r_buzzer   <= 1'b1;
                    r_ringing  <= 1'b1;
                    r_snoozing <= 1'b0;
                end
            end else if (tick) begin
                if (!w_done) begin
                    r_dcnt <= r_dcnt - W'(1);
                end else begin
                    // Exit transitions: a tick arriving while the counter reads zero.
                    case (r_state)
                        S_BEEP: begin
                            r_buzzer <= 1'b0;
                            if (r_bcnt < BCNT_LAST) begin
                                r_state <= S_GAP;
                                r_dcnt  <= GAP_LOAD;
                            end else begin
                                r_state <= S_PAUSE;
                                r_dcnt  <= PAUSE_LOAD;
                            end
                        end
                        S_GAP: begin
                            r_state  <= S_BEEP;
                            r_dcnt   <= BEEP_LOAD;
                            r_bcnt   <= r_bcnt + BW'(1);
                            r_buzzer <= 1'b1;
                        end
                        S_PAUSE: begin
                            if (r_gcnt < GCNT_LAST) begin
                                r_state  <= S_BEEP;
                                r_dcnt   <= BEEP_LOAD;
                                r_bcnt   <= '0;
                                r_gcnt   <= r_gcnt + GW'(1);
                                r_buzzer <= 1'b1;
                            end else begin
                                r_state   <= S_IDLE;
                                r_dcnt    <= '0;
                                r_bcnt    <= '0;
                                r_gcnt    <= '0;
                                r_buzzer  <= 1'b0;
                                r_ringing <= 1'b0;
                            end
                        end
                        S_SNOOZE: begin
                            r_state    <= S_BEEP;
                            r_dcnt     <= BEEP_LOAD;
                            r_bcnt     <= '0;
                            r_gcnt     <= '0;
                            r_buzzer   <= 1'b1;
                            r_snoozing <= 1'b0;
                        end
                        default: begin
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_alarm_beep_sequencer.sv
// Directed bench for alarm_beep_sequencer: ring pattern, auto-off, snooze, stop, enable and reset.
module tb_alarm_beep_sequencer;

    logic clk;
    logic rst;
    logic tick;
    logic alarm_en;
    logic alarm_match;
    logic snooze;
    logic stop;
    logic buzzer;
    logic ringing;
    logic snoozing;

    int n_checks = 0;
    int n_errors = 0;

    alarm_beep_sequencer #(
        .BEEP_TICKS  (2),
        .GAP_TICKS   (2),
        .BEEPS       (3),
        .PAUSE_TICKS (20),
        .GROUPS      (2),
        .SNOOZE_TICKS(8),
        .W           (13)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .alarm_en   (alarm_en),
        .alarm_match(alarm_match),
        .snooze     (snooze),
        .stop       (stop),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozing   (snoozing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected buzzer within a 30-tick group: B B G G B B G G B B then 20 pause ticks.
    function automatic logic pat(input int n);
        int idx;
        idx = n % 30;
        return (idx < 10) && ((idx % 4) < 2);
    endfunction

    task automatic run_groups(input string tag);
        for (int n = 0; n < 60; n++) begin
            check({tag, "_buzzer"}, buzzer, pat(n));
            check({tag, "_ringing"}, ringing, 1);
            check({tag, "_snoozing"}, snoozing, 0);
            cyc(1);
        end
        check({tag, "_autooff"}, ringing, 0);
        check({tag, "_autooff_buzzer"}, buzzer, 0);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; alarm_en = 1'b0; alarm_match = 1'b0;
        snooze = 1'b0; stop = 1'b0;
        cyc(2);
        check("rst_buzzer", buzzer, 0);
        check("rst_ringing", ringing, 0);
        check("rst_snoozing", snoozing, 0);
        check("rst_dcnt", 32'(dut.r_dcnt), 0);
        rst = 1'b1;

        // Basic ring and auto-off after two groups
        tick = 1'b1; alarm_en = 1'b1;
        cyc(1);
        alarm_match = 1'b1;
        cyc(1);
        check("trig_lat_buzzer", buzzer, 0);
        check("trig_lat_ringing", ringing, 0);
        cyc(1);
        run_groups("ring");
        for (int i = 0; i < 20; i++) begin
            check("held_no_retrig", ringing, 0);
            cyc(1);
        end

        // Snooze in the second beep of the second group; restart must reset gcnt
        alarm_match = 1'b0;
        cyc(1);
        alarm_match = 1'b1;
        cyc(2);
        check("snz_first_beep", buzzer, 1);
        cyc(34);
        check("snz_beep2", buzzer, 1);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        check("snz_ringing", ringing, 1);
        for (int i = 0; i < 8; i++) begin
            check("snz_active", snoozing, 1);
            check("snz_quiet", buzzer, 0);
            cyc(1);
        end
        run_groups("resume");

        // Stop, then held match for 500 cycles must not retrigger
        alarm_match = 1'b0;
        cyc(1);
        alarm_match = 1'b1;
        cyc(2);
        check("stop_pre_beep", buzzer, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_buzzer", buzzer, 0);
        check("stop_ringing", ringing, 0);
        for (int i = 0; i < 500; i++) begin
            check("stop_hold", ringing, 0);
            cyc(1);
        end
        alarm_match = 1'b0;
        cyc(1);
        alarm_match = 1'b1;
        cyc(1);
        check("refire_lat", ringing, 0);
        cyc(1);
        check("refire_buzzer", buzzer, 1);
        check("refire_ringing", ringing, 1);

        // Stop + snooze + tick together while beeping
        stop = 1'b1; snooze = 1'b1;
        cyc(1);
        stop = 1'b0; snooze = 1'b0;
        check("combo_ringing", ringing, 0);
        check("combo_snoozing", snoozing, 0);
        check("combo_buzzer", buzzer, 0);

        // Rising match while disarmed is dropped
        alarm_en = 1'b0; alarm_match = 1'b0;
        cyc(1);
        alarm_match = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("disarmed", ringing, 0);
        end
        alarm_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("rearm_no_edge", ringing, 0);
        end

        // Reset mid-pause with tick high
        alarm_match = 1'b0;
        cyc(1);
        alarm_match = 1'b1;
        cyc(2);
        alarm_match = 1'b0;
        check("rstp_beep", buzzer, 1);
        cyc(12);
        check("rstp_pause_buzzer", buzzer, 0);
        check("rstp_pause_ringing", ringing, 1);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("rstp_buzzer", buzzer, 0);
        check("rstp_ringing", ringing, 0);
        check("rstp_snoozing", snoozing, 0);
        check("rstp_dcnt", 32'(dut.r_dcnt), 0);
        check("rstp_bcnt", 32'(dut.r_bcnt), 0);
        check("rstp_gcnt", 32'(dut.r_gcnt), 0);
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            check("rstp_idle_ring", ringing, 0);
            check("rstp_idle_buzz", buzzer, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alarm_beep_sequencer.md
# alarm_beep_sequencer

Controller that sequences the alarm's tick-based duration down-counter to produce the audible ring pattern. On an alarm match it drives the buzzer in groups of BEEPS short beeps separated by gaps, then a longer silent pause. It repeats groups until stopped, snoozed or timed out. It sits between the time/alarm compare logic and the buzzer output. It owns the load/decrement/done control of one embedded down-counter, which is shared across all ring phases.

## Interface
- BEEP_TICKS, 2, ticks buzzer is on per beep (≥1)
- GAP_TICKS, 2, silent ticks between beeps in a group (≥1)
- BEEPS, 3, beeps per group (≥1)
- PAUSE_TICKS, 20, silent ticks after the last beep of a group (≥1)
- GROUPS, 30, groups before automatic stop (≥1)
- SNOOZE_TICKS, 6000, silent ticks in snooze before ringing resumes (≥1)
- W, 13, duration counter width; must hold max(tick param)−1
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-low; one clock; no other reset or clock
- tick  input  1  single-cycle time-base strobe
- alarm_en  input  1  alarm armed; low acts as a continuous stop
- alarm_match  input  1  level, high while current time equals alarm time
- snooze  input  1  single-cycle snooze request
- stop  input  1  single-cycle stop request
- buzzer  output  1  registered, high only in BEEP
- ringing  output  1  registered, high in any state except IDLE
- snoozing  output  1  registered, high only in SNOOZE

## Operation
- States: IDLE, BEEP, GAP, PAUSE, SNOOZE.
- Embedded down-counter dcnt[W-1:0]:
  - Loaded with N−1 on every state entry.
  - Decremented on tick while nonzero.
  - done = (dcnt == 0).
- A state with duration N lasts exactly N ticks. It exits on the tick that arrives while done = 1.
- Beep index bcnt counts 0..BEEPS−1. Group count gcnt counts 0..GROUPS−1.
- Trigger: rising edge of alarm_match, from a registered previous value, while in IDLE and alarm_en = 1.
  - On trigger: go to BEEP, load BEEP_TICKS−1, bcnt = 0, gcnt = 0.
  - alarm_match held high does not retrigger.
- BEEP exit:
  - If bcnt < BEEPS−1: go to GAP.
  - Otherwise: go to PAUSE.
- GAP exit: go to BEEP and increment bcnt.
- PAUSE exit:
  - If gcnt < GROUPS−1: go to BEEP, bcnt = 0, increment gcnt.
  - Otherwise: go to IDLE (auto-off).
- snooze in BEEP, GAP or PAUSE: go to SNOOZE and load SNOOZE_TICKS−1. snooze in IDLE or SNOOZE is ignored.
- SNOOZE exit: go to BEEP, bcnt = 0, gcnt = 0.
- Per-cycle priority: rst low > (stop or alarm_en low) → IDLE > snooze > trigger/tick-driven advance.
  - A tick coinciding with snooze or stop is consumed by the higher-priority action.
- Reset mid-operation: the next edge forces IDLE, and dcnt, bcnt, gcnt and all outputs to 0, regardless of tick, snooze or stop.
- A trigger coinciding with stop or alarm_en low is dropped. The match edge is still recorded, so no ring starts until the next rising edge.

## Timing
- Reset values: state IDLE, buzzer 0, ringing 0, snoozing 0, dcnt 0, bcnt 0, gcnt 0, previous-match register 0.
- Outputs are decoded from the registered state, with no combinational path from inputs.
- Trigger latency: alarm_match rises in cycle k → buzzer = 1 from cycle k+2. This is one cycle for edge detection plus one for the state register.
- stop/snooze latency: asserted in cycle k → buzzer = 0 from cycle k+1.
- Ring period per group = BEEPS·BEEP_TICKS + (BEEPS−1)·GAP_TICKS + PAUSE_TICKS ticks.
  - Defaults: 6 + 4 + 20 = 30 ticks.
- Auto-off occurs after exactly GROUPS full groups. There is no partial group.
- dcnt never wraps: decrement is inhibited at 0. A tick at 0 only causes the state exit.

## Test plan
- Reset, then tick every cycle and pulse alarm_match:
  - buzzer high for 2, low 2, high 2, low 2, high 2, then low 20; the pattern repeats.
  - ringing = 1 throughout.
- GROUPS = 2, tick every cycle: ringing falls exactly 60 ticks after the first buzzer cycle, and state returns to IDLE.
- snooze during the 2nd beep:
  - buzzer 0 next cycle, snoozing = 1 for SNOOZE_TICKS ticks.
  - Then the pattern restarts at beep 0 with gcnt = 0.
- alarm_match held high for 500 cycles after stop: no retrigger. A fresh 0→1 edge restarts ringing 2 cycles later.
- Simultaneous stop + snooze + tick in BEEP → IDLE, snoozing = 0. alarm_en = 0 with alarm_match rising → no ringing.
- rst low for one cycle mid-PAUSE with tick high → next cycle all outputs 0, state IDLE. Subsequent ticks produce no activity.
